// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing a shared-memory multicycle MIPS-subset datapath through fetch/decode/execute/memory/writeback.
// Define PERF_CNT_EN to add the cycle_cnt_o / retire_cnt_o performance counters.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        zero_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic [1:0]  pc_src_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        trap_o,
  output logic [3:0]  state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retire_cnt_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_wait;
  logic             timeout;

  // zero_i qualifies the PC write inside the datapath; sequencing never depends on it.
  logic unused_zero;
  assign unused_zero = zero_i;

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout  = (MEM_TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT);
  assign state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // An ack arriving on the timeout cycle still completes the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack_i)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_J:            state_d = S_JUMP;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack_i)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ack_i)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase

    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (mem_wait && !mem_ack_i && (wait_cnt_q != '1))
      wait_cnt_d = wait_cnt_q + 1'b1;
    else
      wait_cnt_d = wait_cnt_q;
  end

  // Outputs are forced to their idle values while rst_i is high so no write lands after reset.
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = ALU_NONE;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    trap_o          = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_b_o = 2'b01;
          alu_op_o    = ALU_ADD;
          ir_write_o  = mem_ack_i;
          pc_write_o  = mem_ack_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          alu_op_o    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          mem_we_o  = 1'b1;
        end
        S_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNC;
        end
        S_WB_R: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_WB_I: reg_write_o = 1'b1;
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_src_o        = 2'b01;
        end
        S_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'b10;
        end
        S_TRAP: trap_o = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        retire;

  always_comb begin
    retire       = (state_d == S_FETCH) &&
                   (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP});
    cycle_cnt_d  = cycle_cnt_q + ((state_q != S_TRAP) ? 32'd1 : 32'd0);
    retire_cnt_d = retire_cnt_q + (retire ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table for every state and corner case, then randomized
// instruction streams with random memory latency against a phase-list reference model.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_i, zero_i, mem_ack_i;
  logic [5:0]  instr_op_i;
  logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o;
  logic [1:0]  pc_src_o, alu_src_b_o;
  logic        alu_src_a_o, reg_dst_o, reg_write_o, mem_to_reg_o, trap_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  state_o;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_o, retire_cnt_o;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .trap_o(trap_o), .state_o(state_o)
`ifdef PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
`endif
  );

  // {req, we, iord, ir_wr, pc_wr, pc_wr_cond, pc_src[2], src_a, src_b[2], alu_op[3], reg_dst, reg_wr, mem_to_reg, trap}
  logic [17:0] outs;
  assign outs = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o, pc_src_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, reg_write_o, mem_to_reg_o, trap_o};

  localparam logic [17:0] O_IDLE = 18'b0_0_0_0_0_0_00_0_00_111_0_0_0_0;
  localparam logic [17:0] O_FW   = 18'b1_0_0_0_0_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] O_FA   = 18'b1_0_0_1_1_0_00_0_01_000_0_0_0_0;
  localparam logic [17:0] O_DEC  = 18'b0_0_0_0_0_0_00_0_11_000_0_0_0_0;
  localparam logic [17:0] O_EXR  = 18'b0_0_0_0_0_0_00_1_00_010_0_0_0_0;
  localparam logic [17:0] O_WBR  = 18'b0_0_0_0_0_0_00_0_00_111_1_1_0_0;
  localparam logic [17:0] O_EXA  = 18'b0_0_0_0_0_0_00_1_10_000_0_0_0_0;
  localparam logic [17:0] O_EXS  = 18'b0_0_0_0_0_0_00_1_10_011_0_0_0_0;
  localparam logic [17:0] O_WBI  = 18'b0_0_0_0_0_0_00_0_00_111_0_1_0_0;
  localparam logic [17:0] O_MRD  = 18'b1_0_1_0_0_0_00_0_00_111_0_0_0_0;
  localparam logic [17:0] O_MWR  = 18'b1_1_1_0_0_0_00_0_00_111_0_0_0_0;
  localparam logic [17:0] O_WBM  = 18'b0_0_0_0_0_0_00_0_00_111_0_1_1_0;
  localparam logic [17:0] O_BR   = 18'b0_0_0_0_0_1_01_1_00_001_0_0_0_0;
  localparam logic [17:0] O_JMP  = 18'b0_0_0_0_1_0_10_0_00_111_0_0_0_0;
  localparam logic [17:0] O_TRP  = 18'b0_0_0_0_0_0_00_0_00_111_0_0_0_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    int          st;    // -1: state not checked
    logic [17:0] outs;
  } vec_t;

  vec_t        vecs[$];
  int          nvec = 0;
  int          nmis = 0;
  int unsigned m_cyc = 0;
  int unsigned m_ret = 0;

  function automatic void add(input logic r, input logic [5:0] op, input logic z, input logic a,
                              input int st, input logic [17:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.ack = a; v.st = st; v.outs = o;
    vecs.push_back(v);
  endfunction

  function automatic void add_fd(input logic [5:0] op);
    add(1'b0, op, 1'b0, 1'b1, 0, O_FA);
    add(1'b0, op, 1'b0, 1'b1, 1, O_DEC);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic a);
    rst_i = r; instr_op_i = op; zero_i = z; mem_ack_i = a;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One random-phase cycle: expected state and the key enables follow from the phase alone.
  task automatic rcyc(input int p, input logic a, input logic [5:0] op);
    logic [5:0] ev;
    drive(1'b0, op, 1'($urandom_range(0, 1)), a);
    ev = {(p == 0 || p == 3 || p == 4), (p == 4), (p == 5 || p == 7 || p == 9),
          (p == 0 && a), ((p == 0 && a) || p == 11), (p == 15)};
    chk($sformatf("rnd op%0d state", op), 32'(state_o), 32'(p));
    chk($sformatf("rnd op%0d st%0d enables", op, p),
        32'({mem_req_o, mem_we_o, reg_write_o, ir_write_o, pc_write_o, trap_o}), 32'(ev));
    if (p == 8) chk("rnd exec_i alu_op", 32'(alu_op_o), (op == 6'd10) ? 32'd3 : 32'd0);
    if (p == 10) chk("rnd branch", 32'({pc_write_cond_o, alu_op_o}), 32'(4'b1001));
    if (p != 15) m_cyc++;
    tick();
  endtask

  task automatic rreset();
    drive(1'b1, 6'd0, 1'b0, 1'b1);
    tick();
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic run_instr(input logic [5:0] op);
    int seq[$];
    bit trapped;
    trapped = 1'b0;
    case (op)
      6'd0:        seq = {0, 1, 6, 7};
      6'd2:        seq = {0, 1, 11};
      6'd4:        seq = {0, 1, 10};
      6'd8, 6'd10: seq = {0, 1, 8, 9};
      6'd35:       seq = {0, 1, 2, 3, 5};
      6'd43:       seq = {0, 1, 2, 4};
      default:     seq = {0, 1, 15};
    endcase
    foreach (seq[k]) begin
      int p;
      int w;
      p = seq[k];
      if (p == 0 || p == 3 || p == 4) begin
        w = $urandom_range(0, 5);
        for (int j = 0; j < w && j < int'(TO); j++) rcyc(p, 1'b0, op);
        if (w >= int'(TO)) trapped = 1'b1;
        else rcyc(p, 1'b1, op);
      end else if (p == 15) begin
        trapped = 1'b1;
      end else begin
        rcyc(p, 1'($urandom_range(0, 1)), op);
      end
      if (trapped) break;
    end
    if (trapped) begin
      for (int j = 0; j < 3; j++) rcyc(15, 1'($urandom_range(0, 1)), op);
      rreset();
    end else begin
      m_ret++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] legal [7];
    legal = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};

    // R-type, single-cycle acks
    add(1'b1, 6'd0, 1'b0, 1'b1, -1, O_IDLE);
    add_fd(6'd0);
    add(1'b0, 6'd0, 1'b0, 1'b1, 6, O_EXR);
    add(1'b0, 6'd0, 1'b0, 1'b1, 7, O_WBR);
    // LW with one fetch wait and two data waits
    add(1'b0, 6'd35, 1'b0, 1'b0, 0, O_FW);
    add_fd(6'd35);
    add(1'b0, 6'd35, 1'b0, 1'b1, 2, O_EXA);
    add(1'b0, 6'd35, 1'b0, 1'b0, 3, O_MRD);
    add(1'b0, 6'd35, 1'b0, 1'b0, 3, O_MRD);
    add(1'b0, 6'd35, 1'b0, 1'b1, 3, O_MRD);
    add(1'b0, 6'd35, 1'b0, 1'b1, 5, O_WBM);
    // BEQ taken and not taken
    add(1'b0, 6'd4, 1'b1, 1'b1, 0, O_FA);
    add(1'b0, 6'd4, 1'b1, 1'b0, 1, O_DEC);
    add(1'b0, 6'd4, 1'b1, 1'b0, 10, O_BR);
    add(1'b0, 6'd4, 1'b0, 1'b1, 0, O_FA);
    add(1'b0, 6'd4, 1'b0, 1'b0, 1, O_DEC);
    add(1'b0, 6'd4, 1'b0, 1'b0, 10, O_BR);
    // SLTI, ADDI, J
    add_fd(6'd10);
    add(1'b0, 6'd10, 1'b0, 1'b0, 8, O_EXS);
    add(1'b0, 6'd10, 1'b0, 1'b0, 9, O_WBI);
    add_fd(6'd8);
    add(1'b0, 6'd8, 1'b0, 1'b0, 8, O_EXA);
    add(1'b0, 6'd8, 1'b0, 1'b0, 9, O_WBI);
    add_fd(6'd2);
    add(1'b0, 6'd2, 1'b0, 1'b1, 11, O_JMP);
    // SW, then SW interrupted by reset while the write is pending
    add_fd(6'd43);
    add(1'b0, 6'd43, 1'b0, 1'b0, 2, O_EXA);
    add(1'b0, 6'd43, 1'b0, 1'b1, 4, O_MWR);
    add_fd(6'd43);
    add(1'b0, 6'd43, 1'b0, 1'b0, 2, O_EXA);
    add(1'b0, 6'd43, 1'b0, 1'b0, 4, O_MWR);
    add(1'b1, 6'd43, 1'b0, 1'b1, 4, O_IDLE);
    // Fetch timeout after TO wait cycles, then ack on the last allowed cycle
    for (int i = 0; i < int'(TO); i++) add(1'b0, 6'd0, 1'b0, 1'b0, 0, O_FW);
    add(1'b0, 6'd0, 1'b0, 1'b0, 15, O_TRP);
    add(1'b1, 6'd0, 1'b0, 1'b0, 15, O_IDLE);
    for (int i = 0; i < int'(TO) - 1; i++) add(1'b0, 6'd0, 1'b0, 1'b0, 0, O_FW);
    add(1'b0, 6'd0, 1'b0, 1'b1, 0, O_FA);
    add(1'b0, 6'd0, 1'b0, 1'b0, 1, O_DEC);
    add(1'b0, 6'd0, 1'b0, 1'b0, 6, O_EXR);
    add(1'b0, 6'd0, 1'b0, 1'b0, 7, O_WBR);
    // Illegal opcode: sticky trap with ack toggling, cleared by reset
    add_fd(6'd5);
    for (int i = 0; i < 20; i++) add(1'b0, 6'd5, 1'b0, 1'(i & 1), 15, O_TRP);
    add(1'b1, 6'd5, 1'b0, 1'b1, 15, O_IDLE);
    add(1'b0, 6'd0, 1'b0, 1'b0, 0, O_FW);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ack);
      if (vecs[i].st >= 0) chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("vec%0d outputs", i), 32'(outs), 32'(vecs[i].outs));
      tick();
    end

    rreset();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (op inside {legal});
      end else begin
        op = legal[$urandom_range(0, 6)];
      end
      run_instr(op);
    end

`ifdef PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt_o, 32'(m_cyc));
    chk("retire_cnt", retire_cnt_o, 32'(m_ret));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-memory, multicycle MIPS-subset datapath (PC, IR, register file, one ALU, one memory port).
- Fetches an instruction, decodes its 6-bit opcode, then steps through execute, memory and writeback, one phase per cycle.
- Stalls on a req/ack handshake to a variable-latency memory.
- Replaces per-instruction combinational decode for the multicycle CPU variant.

Parameters:
- MEM_TIMEOUT, 16, cycles mem_req_o may wait for mem_ack_i before entering TRAP; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_op_i  in  6  opcode field of the IR (valid from DECODE onward)
- zero_i  in  1  ALU zero flag
- mem_ack_i  in  1  memory completes the current access this cycle
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  1 = write, 0 = read
- iord_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load IR
- pc_write_o  out  1  unconditional PC write
- pc_write_cond_o  out  1  PC write if zero_i
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op_o  out  3  000 add, 001 sub/beq, 010 R-type funct, 011 slti, 111 none
- reg_dst_o  out  1  1 = rd, 0 = rt
- reg_write_o  out  1  register file write enable
- mem_to_reg_o  out  1  writeback from memory data
- trap_o  out  1  sticky: illegal opcode or memory timeout
- state_o  out  4  current state encoding, for debug

Behaviour:
- State encoding:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WR, 5 WB_MEM, 6 EXEC_R, 7 WB_R
  - 8 EXEC_I, 9 WB_I, 10 BRANCH, 11 JUMP, 15 TRAP
- Reset:
  - state = FETCH, wait counter = 0, trap_o = 0.
  - All outputs = 0 except alu_op_o = 111; the FETCH-state outputs below apply from the first cycle after reset.
  - Reset mid-access drops mem_req_o the next cycle; no write is committed after reset is seen.
- FETCH:
  - mem_req_o = 1, iord_o = 0, alu_src_a_o = 0, alu_src_b_o = 01, alu_op_o = 000.
  - ir_write_o and pc_write_o assert only in the cycle mem_ack_i = 1 (combinational with ack); FSM then moves to DECODE.
  - Without ack: FSM holds and the counter increments.
- DECODE:
  - alu_src_a_o = 0, alu_src_b_o = 11, alu_op_o = 000 (branch target precomputed into ALUOut).
  - Next state by opcode: 0 -> EXEC_R; 2 -> JUMP; 4 -> BRANCH; 8 or 10 -> EXEC_I; 35 or 43 -> MEM_ADDR; any other -> TRAP.
- EXEC_R: alu_src_a_o = 1, alu_src_b_o = 00, alu_op_o = 010 -> WB_R.
- WB_R: reg_write_o = 1, reg_dst_o = 1 -> FETCH.
- EXEC_I: alu_src_a_o = 1, alu_src_b_o = 10, alu_op_o = 000 (opcode 8) or 011 (opcode 10) -> WB_I.
- WB_I: reg_write_o = 1, reg_dst_o = 0 -> FETCH.
- MEM_ADDR: alu_src_a_o = 1, alu_src_b_o = 10, alu_op_o = 000 -> MEM_RD (opcode 35) or MEM_WR (opcode 43).
- MEM_RD and MEM_WR:
  - mem_req_o = 1, iord_o = 1, mem_we_o = 1 in MEM_WR only.
  - Hold until ack; on ack MEM_RD -> WB_MEM, MEM_WR -> FETCH.
- WB_MEM: reg_write_o = 1, mem_to_reg_o = 1, reg_dst_o = 0 -> FETCH.
- BRANCH: alu_src_a_o = 1, alu_src_b_o = 00, alu_op_o = 001, pc_write_cond_o = 1, pc_src_o = 01 -> FETCH.
- JUMP: pc_write_o = 1, pc_src_o = 10 -> FETCH.
- TRAP: trap_o = 1, all enables 0, FSM stays in TRAP until rst_i.
- Timing with single-cycle ack:
  - R-type, I-type ALU, BEQ, J, SW: 4, 4, 3, 3, 4 cycles.
  - LW: 5 cycles.
  - Each extra ack-wait cycle adds 1.
- Timeout:
  - Wait counter clears on every state change.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT while still waiting: next state = TRAP and mem_req_o drops.
  - An ack in the same cycle as the timeout wins.
- mem_ack_i outside a request state is ignored.
- Only one write enable class is active per state; reg_write_o and mem_we_o are never both 1.

Optional Feature:
- PERF_CNT_EN, when defined:
  - Adds outputs cycle_cnt_o[31:0] and retire_cnt_o[31:0], both cleared by rst_i.
  - cycle_cnt_o increments every non-TRAP cycle.
  - retire_cnt_o increments on each transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR, BRANCH or JUMP.
  - Both counters wrap modulo 2^32.
- Without the macro: neither port nor counter exists and all other behaviour is identical.

Test Plan:
- Reset, ack tied 1, opcode 0 -> states 0,1,6,7,0; reg_write_o = 1 with reg_dst_o = 1 only in state 7; 4 cycles.
- Opcode 35, fetch ack after 1 wait cycle, data ack after 2 -> states 0,0,1,2,3,3,3,5,0; mem_to_reg_o = 1 in state 5; iord_o = 1 only in state 3.
- Opcode 4 with zero_i = 1, then with zero_i = 0 -> pc_write_cond_o = 1 and alu_op_o = 001 in state 10 for both; 3 cycles each.
- Opcode 10 -> alu_op_o = 011 in state 8; opcode 43 -> mem_we_o = 1 in state 4, reg_write_o never 1.
- Opcode 6'd5 -> state 15, trap_o = 1 held for 20 cycles with ack toggling; rst_i pulse -> state 0, trap_o = 0.
- MEM_TIMEOUT = 4, ack held 0 in FETCH -> trap after 4 wait cycles; repeat with ack on the 4th cycle -> DECODE, no trap.
